// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and run-control sequencer with branch-target LUT
// Steps the PC by increment, stall or LUT branch and counts RUN cycles for a program run.
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [LUT_W-1:0] branch_idx,
  input  logic             cfg_we,
  input  logic [LUT_W-1:0] cfg_idx,
  input  logic [PC_W-1:0]  cfg_data,
  output logic [PC_W-1:0]  instr_addr,
  output logic             run,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int LUT_N = 1 << LUT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_q [LUT_N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  // Branch reads happen combinationally from lut_q, so a same-edge write is seen next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else if (cfg_we) begin
      lut_q[cfg_idx] <= cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (halt) begin
          state_d = S_DONE;
        end else if (!stall) begin
          if (branch_en) begin
            pc_d = lut_q[branch_idx];
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    run_d  = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign instr_addr  = pc_q;
  assign run         = run_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PC_W  = 10;
  localparam int LUT_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             halt = 1'b0;
  logic             stall = 1'b0;
  logic             branch_en = 1'b0;
  logic [LUT_W-1:0] branch_idx = '0;
  logic             cfg_we = 1'b0;
  logic [LUT_W-1:0] cfg_idx = '0;
  logic [PC_W-1:0]  cfg_data = '0;
  logic [PC_W-1:0]  instr_addr;
  logic             run;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  logic             start4 = 1'b0;
  logic [3:0]       pc4;
  logic             run4;
  logic             done4;
  logic [3:0]       cnt4;

  int checks = 0;
  int errors = 0;

  int m_mode;
  int m_pc;
  int m_cnt;
  int m_lut [1 << LUT_W];

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch_en(branch_en), .branch_idx(branch_idx), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .instr_addr(instr_addr),
    .run(run), .done(done), .cycle_count(cycle_count)
  );

  pc_sequencer #(.PC_W(4), .LUT_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .halt(1'b0), .stall(1'b0),
    .branch_en(1'b0), .branch_idx(2'd0), .cfg_we(1'b0),
    .cfg_idx(2'd0), .cfg_data(4'd0), .instr_addr(pc4),
    .run(run4), .done(done4), .cycle_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Modes: 0 idle, 1 running, 2 finished.
  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_cnt  = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic model_edge();
    if (m_mode == 1) begin
      if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      if (halt) m_mode = 2;
      else if (!stall) m_pc = branch_en ? m_lut[branch_idx] : (m_pc + 1) % (1 << PC_W);
    end else if (start) begin
      m_mode = 1;
      m_pc   = 0;
      m_cnt  = 0;
    end
    if (cfg_we) m_lut[cfg_idx] = int'(cfg_data);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},   32'(instr_addr),  32'(m_pc));
    chk({tag, ".run"},  32'(run),         32'(m_mode == 1));
    chk({tag, ".done"}, 32'(done),        32'(m_mode == 2));
    chk({tag, ".cnt"},  32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; branch_en = 0; cfg_we = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    cyc("idle");

    // Start, write LUT[3]=0x120 during the first RUN cycle, count 0..4.
    start = 1; cyc("start"); start = 0;
    chk("start_pc", 32'(instr_addr), 32'd0);
    cfg_we = 1; cfg_idx = 3; cfg_data = 10'h120;
    cyc("seq1"); cfg_we = 0;
    chk("seq_pc1", 32'(instr_addr), 32'd1);
    chk("seq_cnt1", 32'(cycle_count), 32'd1);
    for (int i = 2; i <= 4; i++) cyc("seq");
    chk("seq_pc4", 32'(instr_addr), 32'd4);

    // Stall two cycles at PC 4, second one with a branch also asserted.
    stall = 1; cyc("stall1");
    chk("stall_pc1", 32'(instr_addr), 32'd4);
    branch_en = 1; branch_idx = 3; cyc("stall2");
    chk("stall_pc2", 32'(instr_addr), 32'd4);
    stall = 0; branch_en = 0; cyc("stall_rel");
    chk("stall_pc3", 32'(instr_addr), 32'd5);

    branch_en = 1; branch_idx = 3; cyc("br"); branch_en = 0;
    chk("br_pc", 32'(instr_addr), 32'h120);
    cyc("br_inc");
    chk("br_pc_inc", 32'(instr_addr), 32'h121);

    // Halt, then restart; same-cycle write/branch to LUT[4] must use old value 0.
    halt = 1; cyc("halt0"); halt = 0;
    start = 1; cyc("restart0"); start = 0;
    for (int i = 1; i <= 5; i++) cyc("run5");
    cfg_we = 1; cfg_idx = 4; cfg_data = 10'h055; branch_en = 1; branch_idx = 4;
    cyc("wr_br"); cfg_we = 0;
    chk("wr_br_old", 32'(instr_addr), 32'd0);
    cyc("br_new"); branch_en = 0;
    chk("br_new_pc", 32'(instr_addr), 32'h055);

    // Fresh run, halt and branch together at PC 7.
    halt = 1; cyc("halt1"); halt = 0;
    start = 1; cyc("restart1"); start = 0;
    for (int i = 1; i <= 7; i++) cyc("run7");
    halt = 1; branch_en = 1; branch_idx = 3; cyc("halt7"); idle_inputs();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_run", 32'(run), 32'd0);
    chk("halt_pc", 32'(instr_addr), 32'd7);
    chk("halt_cnt", 32'(cycle_count), 32'd8);
    cyc("done_hold");
    chk("done_hold_cnt", 32'(cycle_count), 32'd8);
    start = 1; cyc("restart2"); start = 0;
    chk("restart_pc", 32'(instr_addr), 32'd0);
    chk("restart_cnt", 32'(cycle_count), 32'd0);
    chk("restart_done", 32'(done), 32'd0);

    // Narrow instance: PC wraps 15->0, counter saturates at 15.
    start4 = 1; @(negedge clk); start4 = 0;
    chk("w4_pc0", 32'(pc4), 32'd0);
    model_edge();
    check_all("w4_main");
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); model_edge(); @(negedge clk);
      chk("w4_pc", 32'(pc4), 32'(k % 16));
      chk("w4_cnt", 32'(cnt4), 32'((k < 15) ? k : 15));
      chk("w4_run", 32'(run4), 32'd1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(0, 3) == 0);
      halt       = ($urandom_range(0, 19) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      branch_en  = ($urandom_range(0, 5) == 0);
      branch_idx = LUT_W'($urandom_range(0, 7));
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_idx    = LUT_W'($urandom_range(0, 7));
      cfg_data   = PC_W'($urandom_range(0, 1023));
      cyc("rand");
    end
    idle_inputs();

    // Asynchronous reset mid-run at PC 9.
    halt = 1; cyc("pre_halt"); halt = 0;
    start = 1; cyc("pre_start"); start = 0;
    for (int i = 1; i <= 9; i++) cyc("run9");
    chk("pre_rst_pc", 32'(instr_addr), 32'd9);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_run", 32'(run), 32'd0);
    @(negedge clk);
    check_all("rst_held");
    reset = 1'b1;
    cyc("post_rst_idle");
    start = 1; cyc("post_rst_start"); start = 0;
    branch_en = 1; branch_idx = 3; cyc("lut_cleared"); branch_en = 0;
    chk("lut_cleared_pc", 32'(instr_addr), 32'd0);
    for (int i = 0; i < 3; i++) cyc("post_rst_run");
    chk("post_rst_pc", 32'(instr_addr), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control sequencer for the TinyChip core. Owns the instruction address presented to instruction memory and steps it by increment, stall, or branch through a programmable branch-target lookup table. Runs a program from `start` to `halt` and reports completion and a cycle count to the top-level controller and testbench.

## Interface
Parameters:
- `PC_W`, 10: program counter / instruction address width.
- `LUT_W`, 5: branch-target LUT index width; the LUT has 2^LUT_W entries of PC_W bits.
- `CNT_W`, 16: cycle counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  begins a program run from PC 0; sampled only in IDLE or DONE.
- `halt`  in  1  decoded halt instruction at the current PC (valid during RUN).
- `stall`  in  1  holds PC for this cycle (valid during RUN).
- `branch_en`  in  1  take branch at the current PC (valid during RUN).
- `branch_idx`  in  LUT_W  LUT entry holding the branch target.
- `cfg_we`  in  1  LUT write enable.
- `cfg_idx`  in  LUT_W  LUT write index.
- `cfg_data`  in  PC_W  LUT write data.
- `instr_addr`  out  PC_W  current PC, drives instruction memory.
- `run`  out  1  core may execute; high only in RUN.
- `done`  out  1  level; high in DONE.
- `cycle_count`  out  CNT_W  number of RUN cycles in the current/last run.

## Operation
- States: IDLE, RUN, DONE. Encoding is implementation choice.
- Reset (asynchronous, `reset`=0): state=IDLE, PC=0, `run`=0, `done`=0, `cycle_count`=0, all LUT entries=0. Takes effect immediately, including mid-RUN.
- IDLE: PC=0. `start`=1 -> RUN with PC=0, `cycle_count`=0.
- RUN: `run`=1. Priority per cycle: `halt` > `stall` > `branch_en` > increment.
  - `halt`: -> DONE; PC holds.
  - `stall`: PC holds.
  - `branch_en`: PC <= LUT[`branch_idx`].
  - otherwise: PC <= PC+1, modulo 2^PC_W (wraps to 0).
  - `cycle_count` increments every RUN cycle, including stall and halt cycles; saturates at all-ones.
  - `start` is ignored in RUN.
- DONE: `done`=1, `run`=0, PC holds the halt address, `cycle_count` holds. `start`=1 -> RUN with PC=0, `cycle_count`=0, `done` drops.
- LUT writes: `cfg_we`=1 writes LUT[`cfg_idx`]=`cfg_data`, accepted in any state. A same-cycle write and branch read of the same index: branch uses the old value, write lands at the edge.
- `instr_addr` is the PC register directly (no combinational path from inputs).

## Timing
- `start` high at edge N (IDLE/DONE) -> from N: state RUN, `instr_addr`=0, `run`=1, `done`=0.
- `halt`, `stall`, `branch_en`, and `branch_idx` are combinational from the core and refer to the `instr_addr` of the same cycle. The effect is visible at the next edge (1-cycle PC latency).
- Halt at the cycle with PC=A -> next cycle: `done`=1, `run`=0, `instr_addr`=A.
- LUT write at edge K is usable by a branch evaluated in the cycle after K.
- All outputs are registered. Reset deassertion is synchronous-safe; the first active edge after release sees IDLE.

## Test plan
- Reset, then `start` pulse: `instr_addr` = 0,1,2,3 on consecutive cycles, `run`=1, `done`=0, `cycle_count` = 1,2,3 lagging by one.
- Write LUT[3]=0x120, run, assert `branch_en` with `branch_idx`=3 at PC=5: PC sequence 5, 0x120, 0x121. Repeat with the write in the same cycle as the branch, old value 0: PC goes 5 -> 0.
- `stall` for 2 cycles at PC=4: PC sequence 4,4,4,5. With `branch_en` also high during the stall, PC still holds.
- From start with no stalls, assert `halt` and `branch_en` together at PC=7: next cycle `done`=1, `run`=0, `instr_addr`=7, `cycle_count`=8. A later `start` gives PC=0, `cycle_count`=0, `done`=0.
- With PC_W=4, run 17 cycles with no branches: PC wraps 15 -> 0. With CNT_W=4, `cycle_count` saturates at 15.
- Drive `reset` low mid-RUN at PC=9 between clock edges: outputs go to reset values without waiting for a clock edge, and LUT entries read back 0 via a branch. After release, `start` runs normally from PC 0.
